// File: rtl/bi_counter_ctrl.sv
// bi_counter_ctrl: memory-mapped sequencer for a 32-bit bi-directional counter.
// A PicoRV32 native-bus slave that drives the counter's mode input and reads
// its count back. Provides start/stop, direction select, a compare match with
// a sticky flag and level interrupt, and one-shot or periodic auto-restart.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   mem_valid  bus request
//   mem_addr   byte address; bits [31:8] select the window, [7:0] the register
//   mem_wdata  write data
//   mem_wstrb  byte write strobes; 0 means read
//   mem_ready  one-cycle access acknowledge
//   mem_rdata  read data, valid while mem_ready is 1
//   ctr_mode   counter mode: 0 hold, 1 up, 2 down (registered)
//   ctr_count  live counter value
//   irq        level interrupt = STATUS.MATCH & CTRL.IRQ_EN
//
// Register map (offset = mem_addr[7:0]):
//   0x00 CTRL      [0] EN, [2:1] DIR, [3] PERIODIC, [4] IRQ_EN (byte 0 only)
//   0x04 STATUS    [0] RUNNING, [1] MATCH (W1C), [2] ERR (W1C), [5:4] state
//   0x08 CMP       compare value, byte strobes honoured
//   0x0C COUNT     live ctr_count
//   0x10 MATCH_CNT wrapping match counter; any write clears it

module bi_counter_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [1:0]  ctr_mode,
  input  logic [31:0] ctr_count,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    RUN    = 2'd2,
    RELOAD = 2'd3
  } state_t;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_CMP    = 8'h08;
  localparam logic [7:0] OFF_COUNT  = 8'h0C;
  localparam logic [7:0] OFF_MCNT   = 8'h10;

  state_t      state;
  state_t      next_state;
  logic [1:0]  next_mode;
  logic [1:0]  next_dir;
  logic [1:0]  state_code;

  logic        ctrl_en;
  logic [1:0]  ctrl_dir;
  logic        ctrl_periodic;
  logic        ctrl_irq_en;
  logic        st_match;
  logic        st_err;
  logic [31:0] cmp;
  logic [31:0] match_cnt;

  logic        sel;
  logic        wr;
  logic        rd;
  logic [7:0]  offset;
  logic        ctrl_wr;
  logic        status_wr;
  logic        cmp_wr;
  logic        mcnt_wr;
  logic        wr_en;
  logic [1:0]  wr_dir;
  logic        dir_ok;
  logic        ctrl_start;
  logic        ctrl_stop;
  logic        ctrl_bad;
  logic        match_hit;
  logic        running;
  logic [31:0] rd_val;

  // Bus decode. The !mem_ready term forces an idle cycle between accesses
  // so a request still held during its acknowledge cycle is not taken twice.
  assign sel       = mem_valid && (mem_addr[31:8] == BASE_ADDR[31:8]) && !mem_ready;
  assign wr        = sel && (mem_wstrb != 4'b0000);
  assign rd        = sel && (mem_wstrb == 4'b0000);
  assign offset    = mem_addr[7:0];
  assign ctrl_wr   = wr && (offset == OFF_CTRL) && mem_wstrb[0];
  assign status_wr = wr && (offset == OFF_STATUS) && mem_wstrb[0];
  assign cmp_wr    = wr && (offset == OFF_CMP);
  assign mcnt_wr   = wr && (offset == OFF_MCNT);

  assign wr_en      = mem_wdata[0];
  assign wr_dir     = mem_wdata[2:1];
  assign dir_ok     = (wr_dir == 2'd1) || (wr_dir == 2'd2);
  assign ctrl_start = ctrl_wr && wr_en && dir_ok;
  assign ctrl_stop  = ctrl_wr && !(wr_en && dir_ok);
  assign ctrl_bad   = ctrl_wr && wr_en && !dir_ok;

  // Only compared in RUN: in START the counter is still loading its start value.
  assign match_hit  = (state == RUN) && (ctr_count == cmp);
  assign running    = (state != IDLE);
  assign state_code = state;
  assign irq        = st_match & ctrl_irq_en;

  // FSM state and registered mode output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ctr_mode <= 2'd0;
    end else begin
      state    <= next_state;
      ctr_mode <= next_mode;
    end
  end

  // A CTRL write overrides the natural sequencing; mode is derived from the
  // state being entered so it changes on the same edge as the state.
  always_comb begin
    next_state = state;
    next_mode  = 2'd0;
    next_dir   = ctrl_wr ? wr_dir : ctrl_dir;
    case (state)
      IDLE:    next_state = IDLE;
      RELOAD:  next_state = START;
      START:   next_state = RUN;
      RUN:     if (match_hit) next_state = ctrl_periodic ? RELOAD : IDLE;
      default: next_state = IDLE;
    endcase
    if (ctrl_start) begin
      next_state = RELOAD;
    end else if (ctrl_stop) begin
      next_state = IDLE;
    end
    if ((next_state == START) || (next_state == RUN)) begin
      next_mode = next_dir;
    end
  end

  // CTRL register. A one-shot match clears EN unless a CTRL write lands
  // in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_en       <= 1'b0;
      ctrl_dir      <= 2'd0;
      ctrl_periodic <= 1'b0;
      ctrl_irq_en   <= 1'b0;
    end else if (ctrl_wr) begin
      ctrl_en       <= wr_en && dir_ok;
      ctrl_dir      <= wr_dir;
      ctrl_periodic <= mem_wdata[3];
      ctrl_irq_en   <= mem_wdata[4];
    end else if (match_hit && !ctrl_periodic) begin
      ctrl_en       <= 1'b0;
    end
  end

  // Sticky STATUS flags: a set in the same cycle as its W1C wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_match <= 1'b0;
      st_err   <= 1'b0;
    end else begin
      if (match_hit) begin
        st_match <= 1'b1;
      end else if (status_wr && mem_wdata[1]) begin
        st_match <= 1'b0;
      end
      if (ctrl_bad) begin
        st_err <= 1'b1;
      end else if (status_wr && mem_wdata[2]) begin
        st_err <= 1'b0;
      end
    end
  end

  // CMP with byte strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmp <= '0;
    end else if (cmp_wr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (mem_wstrb[i]) begin
          cmp[8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  // Match counter; a clear coinciding with a match leaves that match counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_cnt <= '0;
    end else if (mcnt_wr) begin
      match_cnt <= match_hit ? 32'd1 : 32'd0;
    end else if (match_hit) begin
      match_cnt <= match_cnt + 32'd1;
    end
  end

  always_comb begin
    rd_val = '0;
    case (offset)
      OFF_CTRL:   rd_val = {27'd0, ctrl_irq_en, ctrl_periodic, ctrl_dir, ctrl_en};
      OFF_STATUS: rd_val = {26'd0, state_code, 1'b0, st_err, st_match, running};
      OFF_CMP:    rd_val = cmp;
      OFF_COUNT:  rd_val = ctr_count;
      OFF_MCNT:   rd_val = match_cnt;
      default:    rd_val = '0;
    endcase
  end

  // Acknowledge and read data registered together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_ready <= sel;
      mem_rdata <= rd ? rd_val : '0;
    end
  end

endmodule

// File: tb/tb_bi_counter_ctrl.sv
// Bench for bi_counter_ctrl: drives the bus, models the attached counter,
// and checks sequencing timings, end values and register behaviour against
// values computed from the controller's documented rules.

module tb_bi_counter_ctrl;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [1:0]  ctr_mode;
  logic [31:0] ctr_count;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;

  bi_counter_ctrl #(.BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .ctr_mode  (ctr_mode),
    .ctr_count (ctr_count),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Attached counter: loads 0 (up) or all-ones (down) when its mode changes,
  // otherwise steps in the current mode.
  logic [31:0] cnt;
  logic [1:0]  prev_mode;
  assign ctr_count = cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      prev_mode <= 2'd0;
    end else begin
      prev_mode <= ctr_mode;
      if (ctr_mode != prev_mode) begin
        if (ctr_mode == 2'd1) cnt <= '0;
        else if (ctr_mode == 2'd2) cnt <= '1;
      end else if (ctr_mode == 2'd1) begin
        cnt <= cnt + 32'd1;
      end else if (ctr_mode == 2'd2) begin
        cnt <= cnt - 32'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Called at posedge+1; returns at posedge+1 of the acknowledge edge.
  task automatic bus(input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, output logic [31:0] rdata);
    if (mem_ready) begin
      @(posedge clk); #1;
    end
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = strb;
    @(posedge clk); #1;
    check("ready", mem_ready, 1);
    rdata     = mem_rdata;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] data);
    logic [31:0] d;
    bus({BASE[31:8], off}, data, 4'hF, d);
  endtask

  task automatic rd(input logic [7:0] off, output logic [31:0] d);
    bus({BASE[31:8], off}, 32'h0, 4'h0, d);
  endtask

  // Cycles until ctr_mode next reads 0, bounded.
  task automatic wait_drop(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (ctr_mode != 2'd0 && n < 400);
  endtask

  task automatic run_oneshot(input logic [1:0] dir, input logic [31:0] cmpv);
    int          n;
    int          len;
    logic [31:0] d;
    logic [31:0] end_val;
    len     = (dir == 2'd1) ? int'(cmpv) + 3 : int'(32'hFFFF_FFFF - cmpv) + 3;
    end_val = (dir == 2'd1) ? cmpv + 32'd1 : cmpv - 32'd1;
    wr(8'h08, cmpv);
    wr(8'h04, 32'h6);
    wr(8'h10, 32'h0);
    wr(8'h00, {29'd0, dir, 1'b1});
    check("os_reload_mode", ctr_mode, 0);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) check("os_start_mode", ctr_mode, dir);
      if (n == 2) check("os_first_run", ctr_count, (dir == 2'd1) ? 32'h0 : 32'hFFFF_FFFF);
    end while (ctr_mode != 2'd0 && n < 400);
    check("os_len", n, len);
    check("os_end_cnt", ctr_count, end_val);
    repeat (2) begin @(posedge clk); #1; end
    check("os_hold", ctr_count, end_val);
    rd(8'h04, d);
    check("os_status", d, 32'h2);
    rd(8'h00, d);
    check("os_ctrl", d, {29'd0, dir, 1'b0});
    rd(8'h10, d);
    check("os_mcnt", d, 1);
    rd(8'h0C, d);
    check("os_count_rd", d, end_val);
  endtask

  task automatic run_periodic(input logic [1:0] dir, input logic [31:0] cmpv);
    int          n;
    int          per;
    logic [31:0] d;
    per = (dir == 2'd1) ? int'(cmpv) + 3 : int'(32'hFFFF_FFFF - cmpv) + 3;
    wr(8'h08, cmpv);
    wr(8'h04, 32'h6);
    wr(8'h10, 32'h0);
    wr(8'h00, 32'h18 | {29'd0, dir, 1'b1});
    check("p_irq_low", irq, 0);
    wait_drop(n);
    check("p_first", n, per);
    check("p_irq_rise", irq, 1);
    repeat (2) begin
      wait_drop(n);
      check("p_period", n, per);
    end
    rd(8'h10, d);
    check("p_mcnt", d, 3);
    wr(8'h04, 32'h2);
    check("p_irq_clr", irq, 0);
    rd(8'h04, d);
    check("p_status_run", d & 32'h7, 32'h1);
    // Land a MATCH W1C on the same edge as the next match.
    wait_drop(n);
    check("p_wait_bound", (n < 400) ? 32'd1 : 32'd0, 1);
    repeat (per - 1) begin @(posedge clk); #1; end
    wr(8'h04, 32'h2);
    rd(8'h04, d);
    check("p_set_wins", d & 32'h2, 32'h2);
    check("p_irq_kept", irq, 1);
    wr(8'h00, 32'h0);
    check("p_stop_mode", ctr_mode, 0);
    rd(8'h04, d);
    check("p_stop_state", d & 32'h31, 32'h0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] cmp_m;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [7:0]  offs [8];
    logic [7:0]  bad_offs [3];
    logic        seen;
    logic [1:0]  dir;
    int          off;

    offs     = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h40, 8'hFC};
    bad_offs = '{8'h14, 8'h80, 8'hFC};

    reset     = 1'b1;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mode", ctr_mode, 0);
    check("rst_ready", mem_ready, 0);
    check("rst_rdata", mem_rdata, 0);
    check("rst_irq", irq, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      rd(offs[i], d);
      check($sformatf("rst_rd_%02h", offs[i]), d, 0);
      @(posedge clk); #1;
      check("ready_pulse", mem_ready, 0);
    end

    // Requests outside the window are never acknowledged.
    seen      = 1'b0;
    mem_valid = 1'b1;
    mem_wstrb = 4'h0;
    mem_addr  = BASE ^ (32'h100 << $urandom_range(0, 23));
    repeat (4) begin
      @(posedge clk); #1;
      if (mem_ready) seen = 1'b1;
    end
    mem_valid = 1'b0;
    check("unselected", seen, 0);

    run_oneshot(2'd1, 32'd5);
    run_oneshot(2'd2, 32'hFFFF_FFFA);
    run_oneshot(2'd1, 32'd0);
    run_oneshot(2'd2, 32'hFFFF_FFFF);
    repeat (4) begin
      dir = ($urandom_range(0, 1) == 0) ? 2'd1 : 2'd2;
      off = $urandom_range(0, 20);
      run_oneshot(dir, (dir == 2'd1) ? 32'(off) : 32'hFFFF_FFFF - 32'(off));
    end

    run_periodic(2'd1, 32'd5);
    run_periodic(2'd1, 32'($urandom_range(3, 12)));
    run_periodic(2'd2, 32'hFFFF_FFFF - 32'($urandom_range(3, 12)));

    // MATCH_CNT is cleared by a write with any single strobe.
    bus({BASE[31:8], 8'h10}, 32'hFFFF_FFFF, 4'b1000, d);
    rd(8'h10, d);
    check("mcnt_clear", d, 0);

    // Invalid direction with EN set.
    wr(8'h04, 32'h6);
    wr(8'h00, 32'h7);
    check("err_mode", ctr_mode, 0);
    rd(8'h00, d);
    check("err_ctrl", d, 32'h6);
    rd(8'h04, d);
    check("err_status", d, 32'h4);
    repeat (3) begin @(posedge clk); #1; end
    check("err_mode_hold", ctr_mode, 0);
    wr(8'h04, 32'h4);
    wr(8'h00, 32'h6);
    rd(8'h04, d);
    check("err_clr_noen", d, 0);

    // Direction change while running restarts through RELOAD.
    wr(8'h08, 32'd100);
    wr(8'h00, 32'h3);
    repeat (5) begin @(posedge clk); #1; end
    wr(8'h00, 32'h5);
    check("redir_reload", ctr_mode, 0);
    @(posedge clk); #1;
    check("redir_start", ctr_mode, 2);
    @(posedge clk); #1;
    check("redir_first", ctr_count, 32'hFFFF_FFFF);
    wr(8'h00, 32'h0);
    check("redir_stop", ctr_mode, 0);

    // CMP byte strobes.
    wr(8'h08, 32'h0);
    cmp_m = '0;
    repeat (8) begin
      data = $urandom;
      strb = 4'($urandom_range(1, 15));
      bus({BASE[31:8], 8'h08}, data, strb, d);
      for (int b = 0; b < 4; b++)
        if (strb[b]) cmp_m[8*b +: 8] = data[8*b +: 8];
      rd(8'h08, d);
      check("cmp_strobe", d, cmp_m);
    end

    for (int i = 0; i < 3; i++) begin
      wr(bad_offs[i], 32'hFFFF_FFFF);
      rd(bad_offs[i], d);
      check("unmapped", d, 0);
    end

    // Reset in the middle of a periodic run.
    wr(8'h04, 32'h6);
    wr(8'h08, 32'd5);
    wr(8'h00, 32'h1B);
    repeat ($urandom_range(10, 30)) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_mode", ctr_mode, 0);
    check("mid_rst_ready", mem_ready, 0);
    check("mid_rst_rdata", mem_rdata, 0);
    check("mid_rst_irq", irq, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rd(offs[i], d);
      check($sformatf("post_rst_%02h", offs[i]), d, 0);
    end
    check("post_rst_mode", ctr_mode, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
